// File: rtl/fetch_basic.sv
// In-order, single-issue fetch stage. Issues sequential instruction-memory
// requests, holds responses in a small circular buffer and presents them to
// decode in order. A squash from X redirects fetch; responses still owed for
// squashed requests are counted in drop_cnt and discarded when they arrive.
module fetch_basic #(
   parameter int                     p_addr_bits = 32,
   parameter int                     p_inst_bits = 32,
   parameter int                     p_depth     = 2,
   parameter logic [p_addr_bits-1:0] p_reset_pc  = 'h200
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   mem_req_val,
   input  logic                   mem_req_rdy,
   output logic [p_addr_bits-1:0] mem_req_addr,
   input  logic                   mem_resp_val,
   output logic                   mem_resp_rdy,
   input  logic [p_inst_bits-1:0] mem_resp_data,
   output logic                   d_val,
   input  logic                   d_rdy,
   output logic [p_inst_bits-1:0] d_inst,
   output logic [p_addr_bits-1:0] d_pc,
   input  logic                   squash,
   input  logic [p_addr_bits-1:0] branch_target
);

   localparam int p_ptr_bits = (p_depth > 1) ? $clog2(p_depth) : 1;
   localparam int p_cnt_bits = p_ptr_bits + 1;
   localparam logic [p_cnt_bits:0] c_depth = (p_cnt_bits + 1)'(p_depth);

   logic [p_addr_bits-1:0] fetch_pc;
   logic [p_addr_bits-1:0] slot_pc   [p_depth];
   logic [p_inst_bits-1:0] slot_inst [p_depth];
   logic [p_depth-1:0]     slot_done;
   logic [p_ptr_bits-1:0]  alloc_ptr;
   logic [p_ptr_bits-1:0]  resp_ptr;
   logic [p_ptr_bits-1:0]  head_ptr;
   logic [p_cnt_bits-1:0]  count;     // allocated slots
   logic [p_cnt_bits-1:0]  pend_cnt;  // allocated slots still waiting for data
   logic [p_cnt_bits-1:0]  drop_cnt;  // stale responses still owed by memory
   logic                   rst_q;

   logic [p_cnt_bits:0]    occ;
   logic                   req_xfer;
   logic                   resp_keep;
   logic                   resp_drop;
   logic                   d_xfer;

   // Request/decode handshakes and slot-occupancy bookkeeping.
   always_comb begin
      occ          = {1'b0, count} + {1'b0, drop_cnt};
      // rst_q keeps requests off for the first cycle after reset is released
      mem_req_val  = !rst && !rst_q && !squash && (occ < c_depth);
      mem_req_addr = fetch_pc;
      mem_resp_rdy = 1'b1;
      d_val        = !rst && !squash && (count != '0) && slot_done[head_ptr];
      d_inst       = slot_inst[head_ptr];
      d_pc         = slot_pc[head_ptr];
      req_xfer     = mem_req_val && mem_req_rdy;
      resp_drop    = !rst && !squash && mem_resp_val && (drop_cnt != '0);
      resp_keep    = !rst && !squash && mem_resp_val && (drop_cnt == '0);
      d_xfer       = d_val && d_rdy;
   end

   // Delayed reset used to hold off the first request.
   always_ff @(posedge clk) begin
      rst_q <= rst;
   end

   // Control state: pc, pointers, counters, done flags; squash overrides all.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc  <= p_reset_pc;
         alloc_ptr <= '0;
         resp_ptr  <= '0;
         head_ptr  <= '0;
         count     <= '0;
         pend_cnt  <= '0;
         drop_cnt  <= '0;
         slot_done <= '0;
      end else if (squash) begin
         fetch_pc  <= branch_target;
         alloc_ptr <= '0;
         resp_ptr  <= '0;
         head_ptr  <= '0;
         count     <= '0;
         pend_cnt  <= '0;
         slot_done <= '0;
         // everything not yet returned becomes stale; a response landing
         // right now settles one of those debts
         drop_cnt  <= drop_cnt + pend_cnt - p_cnt_bits'(mem_resp_val);
      end else begin
         if (d_xfer) begin
            slot_done[head_ptr] <= 1'b0;
            head_ptr            <= head_ptr + 1'b1;
         end
         if (req_xfer) begin
            slot_done[alloc_ptr] <= 1'b0;
            alloc_ptr            <= alloc_ptr + 1'b1;
            fetch_pc             <= fetch_pc + p_addr_bits'(4);
         end
         if (resp_keep) begin
            slot_done[resp_ptr] <= 1'b1;
            resp_ptr            <= resp_ptr + 1'b1;
         end
         if (resp_drop) begin
            drop_cnt <= drop_cnt - 1'b1;
         end
         count    <= count + p_cnt_bits'(req_xfer) - p_cnt_bits'(d_xfer);
         pend_cnt <= pend_cnt + p_cnt_bits'(req_xfer) - p_cnt_bits'(resp_keep);
      end
   end

   // Slot payload: pc written at allocation, instruction at response.
   always_ff @(posedge clk) begin
      if (req_xfer) begin
         slot_pc[alloc_ptr] <= fetch_pc;
      end
      if (resp_keep) begin
         slot_inst[resp_ptr] <= mem_resp_data;
      end
   end

   // A response must always correspond to an owed or allocated request.
   assert property (@(posedge clk) disable iff (rst)
                    mem_resp_val |-> ((drop_cnt != '0) || (pend_cnt != '0)))
      else $error("fetch_basic: unexpected memory response");

endmodule

// File: tb/tb_fetch_basic.sv
// Randomized bench for fetch_basic with an epoch-based reference model:
// each request is tagged with the redirect epoch it was issued in, and only
// responses from the current epoch reach decode, in request order.
module tb_fetch_basic;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_val, mem_req_rdy;
   logic [31:0] mem_req_addr;
   logic        mem_resp_val, mem_resp_rdy;
   logic [31:0] mem_resp_data;
   logic        d_val, d_rdy;
   logic [31:0] d_inst, d_pc;
   logic        squash;
   logic [31:0] branch_target;

   always #5 clk = ~clk;

   fetch_basic #(.p_addr_bits(32), .p_inst_bits(32), .p_depth(DEPTH), .p_reset_pc(32'h200)) dut (
      .clk(clk), .rst(rst),
      .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
      .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_data(mem_resp_data),
      .d_val(d_val), .d_rdy(d_rdy), .d_inst(d_inst), .d_pc(d_pc),
      .squash(squash), .branch_target(branch_target)
   );

   typedef struct { logic [31:0] addr; logic [31:0] data; int epoch; int ready; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

   mreq_t       mem_q[$];
   ent_t        buf_q[$];
   logic [31:0] rlog[$];
   logic [31:0] dlog[$];
   int          rcyc[$];
   int          dcyc[$];
   int          epoch, cyc;
   logic [31:0] exp_pc;
   bit          after_rst;
   int          total, bad;

   int k_rdy, k_drdy, k_sq, k_resp, k_lat, k_rst_pm;
   bit k_rst, k_rand_tgt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
   endfunction

   function automatic int iget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1000;
   endfunction

   task automatic clear_logs();
      rlog.delete(); dlog.delete(); rcyc.delete(); dcyc.delete();
   endtask

   // compare DUT outputs with the model, then advance the model by one edge
   task automatic update();
      bit    exp_rv, exp_dv;
      mreq_t m;
      exp_rv = !rst && !after_rst && !squash && ((mem_q.size() + buf_q.size()) < DEPTH);
      exp_dv = !rst && !squash && (buf_q.size() > 0);
      chk("mem_req_val", 32'(mem_req_val), 32'(exp_rv));
      chk("d_val", 32'(d_val), 32'(exp_dv));
      chk("mem_resp_rdy", 32'(mem_resp_rdy), 32'd1);
      if (rst) begin
         mem_q.delete();
         buf_q.delete();
         exp_pc    = 32'h200;
         after_rst = 1'b1;
         epoch++;
         return;
      end
      after_rst = 1'b0;
      if (d_val && d_rdy && !squash) begin
         if (buf_q.size() == 0) begin
            chk("d_xfer_empty", 32'(d_val), 32'd0);
         end else begin
            chk("d_pc", d_pc, buf_q[0].pc);
            chk("d_inst", d_inst, buf_q[0].inst);
            void'(buf_q.pop_front());
            dlog.push_back(d_pc);
            dcyc.push_back(cyc);
         end
      end
      if (mem_resp_val) begin
         m = mem_q.pop_front();
         if (!squash && m.epoch == epoch) buf_q.push_back('{pc: m.addr, inst: m.data});
      end
      if (mem_req_val && mem_req_rdy && !squash) begin
         chk("mem_req_addr", mem_req_addr, exp_pc);
         mem_q.push_back('{addr: mem_req_addr, data: $urandom, epoch: epoch,
                           ready: cyc + 1 + int'($urandom_range(k_lat))});
         rlog.push_back(mem_req_addr);
         rcyc.push_back(cyc);
         exp_pc = exp_pc + 32'd4;
      end
      if (squash) begin
         epoch++;
         buf_q.delete();
         exp_pc = branch_target;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      rst           = k_rst || ($urandom_range(999) < k_rst_pm);
      squash        = !rst && ($urandom_range(99) < k_sq);
      branch_target = k_rand_tgt ? (32'h300 + ($urandom_range(63) << 2)) : 32'h300;
      mem_req_rdy   = $urandom_range(99) < k_rdy;
      d_rdy         = $urandom_range(99) < k_drdy;
      mem_resp_val  = 1'b0;
      mem_resp_data = $urandom;
      if (!rst && mem_q.size() > 0 && mem_q[0].ready <= cyc && $urandom_range(99) < k_resp) begin
         mem_resp_val  = 1'b1;
         mem_resp_data = mem_q[0].data;
      end
      @(negedge clk);
      update();
      cyc++;
   endtask

   task automatic do_reset(input int n);
      k_rst = 1'b1;
      repeat (n) step();
      k_rst = 1'b0;
   endtask

   task automatic knobs(input int rdy, input int drdy, input int sq, input int resp, input int lat);
      k_rdy = rdy; k_drdy = drdy; k_sq = sq; k_resp = resp; k_lat = lat;
   endtask

   initial begin
      rst = 1'b1; squash = 1'b0; mem_req_rdy = 1'b0; mem_resp_val = 1'b0; d_rdy = 1'b0;
      mem_resp_data = '0; branch_target = '0;
      total = 0; bad = 0; cyc = 0; epoch = 0; exp_pc = 32'h200; after_rst = 1'b1;
      k_rst = 1'b0; k_rand_tgt = 1'b0; k_rst_pm = 0;
      knobs(100, 100, 0, 100, 0);

      // streaming after reset, 1-cycle memory, decode always ready
      do_reset(3);
      clear_logs();
      repeat (20) step();
      chk("t1_req0", qget(rlog, 0), 32'h200);
      chk("t1_req1", qget(rlog, 1), 32'h204);
      chk("t1_req2", qget(rlog, 2), 32'h208);
      chk("t1_d0", qget(dlog, 0), 32'h200);
      chk("t1_d1", qget(dlog, 1), 32'h204);
      chk("t1_first_lat", 32'(iget(dcyc, 0) - iget(rcyc, 0)), 32'd2);

      // decode stalled: buffer fills after two requests, then drains in order
      do_reset(2);
      knobs(100, 0, 0, 100, 0);
      clear_logs();
      repeat (8) step();
      chk("t2_nreq", 32'(rlog.size()), 32'd2);
      chk("t2_req_blocked", 32'(mem_req_val), 32'd0);
      k_drdy = 100;
      repeat (6) step();
      chk("t2_d0", qget(dlog, 0), 32'h200);
      chk("t2_d1", qget(dlog, 1), 32'h204);
      chk("t2_resume", qget(rlog, 2), 32'h208);

      // squash with two requests outstanding: both responses dropped
      do_reset(2);
      knobs(100, 0, 0, 0, 0);
      clear_logs();
      repeat (4) step();
      chk("t3_nreq", 32'(rlog.size()), 32'd2);
      k_sq = 100;
      step();
      clear_logs();
      knobs(100, 100, 0, 100, 0);
      repeat (12) step();
      chk("t3_req0", qget(rlog, 0), 32'h300);
      chk("t3_d0", qget(dlog, 0), 32'h300);
      chk("t3_d1", qget(dlog, 1), 32'h304);

      // squash coinciding with a response and decode ready
      do_reset(2);
      knobs(100, 0, 0, 0, 0);
      repeat (4) step();
      k_resp = 100;
      step();
      knobs(100, 100, 100, 100, 0);
      step();
      chk("t4_resp_seen", 32'(mem_resp_val), 32'd1);
      chk("t4_no_dxfer", 32'(d_val), 32'd0);
      k_sq = 0;
      clear_logs();
      repeat (10) step();
      chk("t4_d0", qget(dlog, 0), 32'h300);

      // memory not ready: request held with a stable address
      do_reset(2);
      knobs(100, 100, 0, 100, 0);
      step();
      step();
      k_rdy = 0;
      repeat (3) begin
         step();
         chk("t5_val", 32'(mem_req_val), 32'd1);
         chk("t5_addr", mem_req_addr, 32'h204);
      end
      k_rdy = 100;
      clear_logs();
      step();
      chk("t5_accept", qget(rlog, 0), 32'h204);

      // reset in the middle of a full buffer
      do_reset(2);
      knobs(100, 0, 0, 100, 0);
      repeat (6) step();
      chk("t6_full_dval", 32'(d_val), 32'd1);
      k_rst = 1'b1;
      step();
      k_rst = 1'b0;
      clear_logs();
      step();
      chk("t6_dval", 32'(d_val), 32'd0);
      chk("t6_reqval", 32'(mem_req_val), 32'd0);
      k_drdy = 100;
      repeat (4) step();
      chk("t6_restart", qget(rlog, 0), 32'h200);

      // random traffic with redirects and occasional resets
      do_reset(2);
      knobs(70, 60, 5, 70, 3);
      k_rand_tgt = 1'b1;
      k_rst_pm   = 2;
      repeat (3000) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
